// File: rtl/seg_scan_driver.sv
// seg_scan_driver
// Time-multiplexed driver for a multi-digit 7-segment display. Received UART
// bytes scroll into a nibble buffer two digits at a time. A free-running
// prescaler and a digit index then scan the buffer one digit per refresh slot.
// The selected nibble is presented to the hex decoder, and the matching
// active-low anode is driven. Digits never written since reset or clear stay dark.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  clear,
    output logic [3:0]            digit,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PCNT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    logic [3:0]            nib_buf [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dig_vld;
    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] an_nxt;

    // Display buffer: clear wins over a simultaneous byte; a byte shifts older digits left by two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_buf[i] <= 4'h0;
            end
            dig_vld <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                nib_buf[i] <= 4'h0;
            end
            dig_vld <= '0;
        end else if (rx_valid) begin
            for (int i = 2; i < NUM_DIGITS; i++) begin
                nib_buf[i] <= nib_buf[i-2];
                dig_vld[i] <= dig_vld[i-2];
            end
            nib_buf[1]   <= rx_data[7:4];
            nib_buf[0]   <= rx_data[3:0];
            dig_vld[1:0] <= 2'b11;
        end
    end

    // Prescaler and scan index; terminal values are compared explicitly so non-power-of-two sizes wrap correctly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Anode pattern for the selected digit, blanked when that digit holds no data
    always_comb begin
        an_nxt = '1;
        if (dig_vld[idx]) begin
            an_nxt = ~(NUM_DIGITS'(1) << idx);
        end
    end

    // Registered outputs toward the decoder and the anode drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'h0;
            an    <= '1;
        end else begin
            digit <= nib_buf[idx];
            an    <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a queue-of-bytes reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] digit;
    logic [3:0] an;

    int errors = 0;
    int checks = 0;

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .clear    (clear),
        .digit    (digit),
        .an       (an)
    );

    always #5 clk = ~clk;

    // Reference model: bytes since last clear, newest first; edges counted since reset
    logic [7:0]  q[$];
    int unsigned ecnt = 0;
    logic [3:0]  exp_digit = 4'h0;
    logic [3:0]  exp_an = 4'hF;

    function automatic logic [3:0] nib_at(input int s);
        int b;
        logic [7:0] v;
        b = s / 2;
        if (b >= q.size()) return 4'h0;
        v = q[b];
        return (s % 2 == 1) ? v[7:4] : v[3:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            ecnt      <= 0;
            exp_digit <= 4'h0;
            exp_an    <= 4'hF;
        end else begin
            automatic int s = int'((ecnt / RD) % ND);
            exp_digit <= nib_at(s);
            exp_an    <= (s / 2 < q.size()) ? ~(4'b0001 << s) : 4'b1111;
            if (clear) begin
                q.delete();
            end else if (rx_valid) begin
                q.push_front(rx_data);
                if (q.size() > ND / 2) void'(q.pop_back());
            end
            ecnt <= ecnt + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Continuous comparison against the model
    always @(negedge clk) begin
        chk("model_digit", {28'h0, digit}, {28'h0, exp_digit});
        chk("model_an", {28'h0, an}, {28'h0, exp_an});
    end

    // One full scan pass against a literal digit table and lit mask, slot from edges since reset
    task automatic check_pass(input logic [15:0] digs, input logic [3:0] mask, input string nm);
        int s;
        logic [3:0] ea;
        for (int c = 0; c < ND * RD; c++) begin
            @(negedge clk);
            s  = int'(((ecnt - 1) / RD) % ND);
            ea = mask[s] ? ~(4'b0001 << s) : 4'b1111;
            chk({nm, "_an"}, {28'h0, an}, {28'h0, ea});
            chk({nm, "_digit"}, {28'h0, digit}, {28'h0, digs[s*4 +: 4]});
        end
    endtask

    task automatic send(input logic [7:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] v, input string nm);
        bit found = 0;
        for (int c = 0; c < 4 * ND * RD && !found; c++) begin
            @(negedge clk);
            if (an == v) found = 1;
        end
        if (!found) chk({nm, "_timeout"}, {28'h0, an}, {28'h0, v});
    endtask

    logic [3:0] run_tab [16];

    initial begin
        // Reset: dark display with no bytes
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", {28'h0, an}, 32'hF);
        chk("reset_digit", {28'h0, digit}, 32'h0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_an", {28'h0, an}, 32'hF);
        end

        // Scan timing with 0x12 then 0x34
        rx_valid = 1'b1; rx_data = 8'h12;
        @(negedge clk);
        rx_data = 8'h34;
        @(negedge clk);
        rx_valid = 1'b0;
        check_pass(16'h1234, 4'hF, "scan");

        // Run lengths and wrap, aligned on the 0111 -> 1110 transition
        for (int k = 0; k < 16; k++) begin
            run_tab[k] = (k < 4) ? 4'b1110 : (k < 8) ? 4'b1101 : (k < 12) ? 4'b1011 : 4'b0111;
        end
        wait_an(4'b0111, "align_a");
        wait_an(4'b1110, "align_b");
        for (int k = 1; k < 16; k++) begin
            @(negedge clk);
            chk("run_an", {28'h0, an}, {28'h0, run_tab[k]});
        end
        @(negedge clk);
        chk("wrap_an", {28'h0, an}, 32'hE);

        // Partial fill with one byte
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        send(8'hA5);
        check_pass(16'h00A5, 4'b0011, "partial");

        // Scroll: oldest byte drops out
        rx_valid = 1'b1; rx_data = 8'h12;
        @(negedge clk);
        rx_data = 8'h34;
        @(negedge clk);
        rx_data = 8'h56;
        @(negedge clk);
        rx_valid = 1'b0;
        check_pass(16'h3456, 4'hF, "scroll");

        // Clear has priority over a simultaneous byte
        clear = 1'b1; rx_valid = 1'b1; rx_data = 8'hFF;
        @(negedge clk);
        clear = 1'b0; rx_valid = 1'b0;
        check_pass(16'h0000, 4'h0, "clrprio");

        // Async reset in the idx=2 slot, then restart at idx=0
        rx_valid = 1'b1; rx_data = 8'h9C;
        @(negedge clk);
        rx_data = 8'h3E;
        @(negedge clk);
        rx_valid = 1'b0;
        wait_an(4'b1011, "slot2");
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {28'h0, an}, 32'hF);
        chk("async_digit", {28'h0, digit}, 32'h0);
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'h77;
        rst_n = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("restart_an0", {28'h0, an}, 32'hF);
        @(negedge clk);
        chk("restart_an1", {28'h0, an}, 32'hE);
        chk("restart_digit", {28'h0, digit}, 32'h7);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rx_valid = ($urandom_range(0, 3) == 0);
            rx_data  = 8'($urandom);
            clear    = ($urandom_range(0, 80) == 0);
            if ($urandom_range(0, 600) == 0) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        rx_valid = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the board's multi-digit 7-segment display, sitting directly upstream of the per-digit hex-to-segment decoder. It captures each byte strobed out of the UART receiver into a nibble-wide display buffer, scrolling older bytes leftward. It then scans the digits one at a time, presenting the selected hex nibble to the decoder and driving the matching active-low anode. Digits that have never been written since reset or clear stay dark.

## Interface
- NUM_DIGITS, 4, number of display digits; must be even, ≥2
- REFRESH_DIV, 100000, clock cycles each digit is enabled per scan step; ≥2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from UART RX
- rx_valid  in  1  single-cycle strobe; rx_data valid this cycle
- clear  in  1  synchronous clear of display contents
- digit  out  4  hex nibble of currently scanned digit, to decoder input
- an  out  NUM_DIGITS  anode enables, active-low, at most one bit low

## Operation
- Storage: nibble buffer buf[NUM_DIGITS-1:0] plus per-digit flag vld[NUM_DIGITS-1:0]; digit 0 is rightmost.
- Byte capture on rx_valid (clear low):
  - buf[i] <= buf[i-2] and vld[i] <= vld[i-2] for i ≥ 2; the oldest two digits drop out.
  - buf[1] <= rx_data[7:4]; buf[0] <= rx_data[3:0].
  - vld[1:0] <= 2'b11.
- clear high: buf and vld go to 0 next edge; clear has priority over a simultaneous rx_valid, and that byte is discarded.
- Prescaler pcnt counts 0..REFRESH_DIV-1 continuously, wrapping to 0.
- Scan index idx advances by 1 when pcnt == REFRESH_DIV-1; idx wraps NUM_DIGITS-1 -> 0.
- Output registers, updated every clock:
  - digit <= buf[idx].
  - an <= ~(1 << idx) if vld[idx], else all ones (blanked).
- Buffer writes are independent of scanning; a write never disturbs pcnt or idx.
- No state machine beyond the counters: the prescaler and the index counter form the whole sequencer.

## Timing
- Reset (async assert, sync-deasserted externally): buf=0, vld=0, pcnt=0, idx=0, digit=4'h0, an=all ones.
- Output latency: digit/an reflect idx and buf with one cycle of register delay.
  - After idx changes on edge N, the outputs change on edge N+1.
  - A byte captured on edge N is visible on edge N+1 if its digit is currently selected.
- Each digit's anode is low for exactly REFRESH_DIV consecutive cycles per scan pass if valid. A full pass takes NUM_DIGITS*REFRESH_DIV cycles.
- an switches from one enabled digit directly to the next. No cycle has two bits low.
- Back-to-back rx_valid on consecutive cycles: each byte is captured; no strobe is lost.
- rst_n asserted mid-scan or mid-capture: all state clears immediately. After release, scanning restarts at idx=0, pcnt=0.
- Counter widths: pcnt is $clog2(REFRESH_DIV) bits and idx is $clog2(NUM_DIGITS) bits. Both compare explicitly against the terminal value, with no reliance on natural overflow.

## Test plan
- Reset check: hold rst_n low, then release. Required: an=4'b1111 and digit=0 throughout, with all digits dark indefinitely since no bytes arrive.
- Scan timing, REFRESH_DIV=4, after capturing 0x12 and 0x34:
  - Required: an cycles 1110, 1101, 1011, 0111, each for exactly 4 cycles.
  - Required: after 0111 the sequence wraps to 1110.
  - Required: digit shows 4, 3, 2, 1 in step with the anodes.
- Partial fill: one byte 0xA5. Required: digit0=5, digit1=A lit; an[3:2] stay high during their scan slots.
- Scroll: bytes 0x12, 0x34, 0x56 on consecutive cycles. Required: digits 3..0 = 3, 4, 5, 6, and 0x12 is discarded.
- Clear priority: clear and rx_valid (0xFF) in the same cycle after a full buffer. Required: every digit blank next cycle, and 0xFF is not stored.
- Async reset mid-pass: pull rst_n low during the idx=2 slot. Required: an=all ones and digit=0 immediately without waiting for a clock. After release, the first enabled slot is idx=0.
